cpu_clock_controller: RTL and testbench
=======================================

Name: cpu_clock_controller

Overview:
- Run/halt/single-step sequencer for the 8-bit CPU core.
- Divides clkin by a run-time programmable ratio and issues one-cycle clock-enable pulses (cpu_ce) to the CPU datapath. Pulses are issued continuously in RUN and one at a time in STEP.
- Replaces a gated/derived CPU clock with a single-domain clock enable. Sits between the front-panel/debug inputs and the CPU core.

Parameters:
IN_CLK_FRQ  1000000  clkin frequency in Hz
DEFAULT_FRQ  10  cpu_ce rate after reset, in Hz
CNT_W  32  divider counter and cfg_div width
Derived: DEFAULT_DIV = IN_CLK_FRQ/DEFAULT_FRQ - 1. cpu_ce period = div_reg+1 clkin cycles.

Ports:
clkin  input  1  the single clock; all logic on posedge clkin
reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clkin)
run_req  input  1  level; a rising edge requests free-run
halt_req  input  1  level; a rising edge requests halt
step_req  input  1  level; a rising edge requests one cpu_ce pulse
cpu_halted  input  1  CPU executed HLT; level
cfg_wr  input  1  one-cycle strobe: load divider ratio
cfg_div  input  CNT_W  new div_reg value, sampled when cfg_wr=1
cpu_ce  output  1  registered one-clkin-cycle clock enable to the CPU
running  output  1  registered; 1 while the FSM is in RUN
step_busy  output  1  registered; 1 while the FSM is in STEP

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE, counter=0, div_reg=DEFAULT_DIV.
  - cpu_ce=0, running=0, step_busy=0.
  - Edge-detect history registers are set to 1, so an input held high through reset produces no edge.
- Edge detect: for each *_req, edge = req & ~prev; prev <= req every cycle.
- Divider:
  - counter increments every cycle. When counter==div_reg, tick=1 and counter<=0.
  - cfg_wr=1: div_reg<=cfg_div and counter<=0. No tick is produced that cycle, even if the old compare matched.
  - div_reg=0 gives a tick every cycle.
  - counter never exceeds div_reg.
- Entering RUN or STEP clears counter. The first cpu_ce is therefore high during the cycle after the (div_reg+1)-th posedge following entry.
- FSM priority per cycle: halt edge > cpu_halted > run edge > step edge.
  - IDLE:
    - run edge with cpu_halted=0 -> RUN.
    - step edge with cpu_halted=0 -> STEP.
    - Otherwise stay.
  - RUN:
    - cpu_ce <= tick.
    - halt edge or cpu_halted=1 -> IDLE; cpu_ce<=0 that cycle even if tick.
    - run and step edges are ignored.
  - STEP:
    - On tick: cpu_ce<=1 and -> IDLE.
    - halt edge or cpu_halted=1 -> IDLE with no pulse.
    - A further step edge is ignored (no queuing).
- cpu_ce is never high for two consecutive cycles unless div_reg=0 and state=RUN.
- running and step_busy reflect the state register (registered, one cycle after the transition edge).
- cfg_wr during RUN takes effect immediately and keeps the state. The next cpu_ce follows after the new div_reg+1 cycles.
- Reset asserted mid-RUN or mid-STEP: all outputs return to reset values at that posedge. Any pending pulse is dropped.

Optional Feature:
CLK_CTRL_CYCLE_CNT_EN
- Defined:
  - Adds output cpu_cycles [31:0], which counts cpu_ce pulses, wraps 0xFFFFFFFF->0, and resets to 0.
  - Adds input cnt_clr, which clears the count synchronously; it takes priority over the increment in the same cycle.
- Undefined: neither port exists and no counter logic is synthesized.

Test Plan:
- Bench uses IN_CLK_FRQ=100, DEFAULT_FRQ=10, so DEFAULT_DIV=9.
- Release reset, pulse run_req -> running=1; cpu_ce pulses one cycle wide every 10 cycles; first pulse 10 cycles after RUN entry.
- In IDLE, pulse step_req -> step_busy=1; exactly one cpu_ce 10 cycles later; then step_busy=0 and running=0. A second step_req during STEP yields no extra pulse.
- In RUN, cfg_wr=1 with cfg_div=3 -> counter cleared; pulses every 4 cycles. Then cfg_div=0 -> cpu_ce held high continuously.
- In RUN, raise cpu_halted on a tick cycle -> no cpu_ce that cycle; FSM to IDLE. A run_req edge while cpu_halted=1 is ignored.
- Same-cycle halt_req and run_req edges in IDLE -> stays IDLE. Hold run_req high through reset -> no RUN after release. Assert reset mid-RUN -> all outputs 0 next cycle.
- With CLK_CTRL_CYCLE_CNT_EN defined: 5 pulses -> cpu_cycles=5. cnt_clr on a pulse cycle -> cpu_cycles=0.

Source files
------------

// File: rtl/cpu_clock_controller_if.sv
// Front-panel/debug request and CPU clock-enable bundle for cpu_clock_controller.
// Optional CLK_CTRL_CYCLE_CNT_EN adds cnt_clr and cpu_cycles.
interface cpu_clock_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic             run_req;
    logic             halt_req;
    logic             step_req;
    logic             cpu_halted;
    logic             cfg_wr;
    logic [CNT_W-1:0] cfg_div;
    logic             cpu_ce;
    logic             running;
    logic             step_busy;
`ifdef CLK_CTRL_CYCLE_CNT_EN
    logic             cnt_clr;
    logic [31:0]      cpu_cycles;

    modport master (
        output run_req, halt_req, step_req, cpu_halted, cfg_wr, cfg_div, cnt_clr,
        input  cpu_ce, running, step_busy, cpu_cycles
    );
    modport slave (
        input  run_req, halt_req, step_req, cpu_halted, cfg_wr, cfg_div, cnt_clr,
        output cpu_ce, running, step_busy, cpu_cycles
    );
`else
    modport master (
        output run_req, halt_req, step_req, cpu_halted, cfg_wr, cfg_div,
        input  cpu_ce, running, step_busy
    );
    modport slave (
        input  run_req, halt_req, step_req, cpu_halted, cfg_wr, cfg_div,
        output cpu_ce, running, step_busy
    );
`endif
endinterface

// File: rtl/cpu_clock_controller.sv
// Run/halt/single-step sequencer issuing divided one-cycle clock enables to the CPU.
// Optional CLK_CTRL_CYCLE_CNT_EN adds a 32-bit cpu_ce pulse counter with clear.
module cpu_clock_controller #(
    parameter int unsigned IN_CLK_FRQ  = 1000000,
    parameter int unsigned DEFAULT_FRQ = 10,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                    clkin,
    input  logic                    reset,
    cpu_clock_controller_if.slave   bus
);
    localparam logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(IN_CLK_FRQ / DEFAULT_FRQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q;
    logic             run_prev_q, halt_prev_q, step_prev_q;
    logic             cpu_ce_q, running_q, step_busy_q;

    logic run_edge, halt_edge, step_edge;
    logic stop, cnt_hit, tick, enter;

    always_comb begin
        run_edge  = bus.run_req  & ~run_prev_q;
        halt_edge = bus.halt_req & ~halt_prev_q;
        step_edge = bus.step_req & ~step_prev_q;
        stop      = halt_edge | bus.cpu_halted;
        cnt_hit   = (cnt_q == div_q);
        // A divider reload suppresses the tick even if the old compare matched
        tick      = cnt_hit & ~bus.cfg_wr;
        enter     = (state_q == ST_IDLE) & ~stop & (run_edge | step_edge);
        cnt_d     = cnt_q + CNT_W'(1);
        if (bus.cfg_wr || enter || cnt_hit) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clkin) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_q       <= DEFAULT_DIV;
            run_prev_q  <= 1'b1;
            halt_prev_q <= 1'b1;
            step_prev_q <= 1'b1;
            cpu_ce_q    <= 1'b0;
            running_q   <= 1'b0;
            step_busy_q <= 1'b0;
        end else begin
            run_prev_q  <= bus.run_req;
            halt_prev_q <= bus.halt_req;
            step_prev_q <= bus.step_req;
            cnt_q       <= cnt_d;
            cpu_ce_q    <= 1'b0;
            if (bus.cfg_wr) begin
                div_q <= bus.cfg_div;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!stop && run_edge) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (!stop && step_edge) begin
                        state_q     <= ST_STEP;
                        step_busy_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end else begin
                        cpu_ce_q <= tick;
                    end
                end
                ST_STEP: begin
                    if (stop) begin
                        state_q     <= ST_IDLE;
                        step_busy_q <= 1'b0;
                    end else if (tick) begin
                        cpu_ce_q    <= 1'b1;
                        state_q     <= ST_IDLE;
                        step_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    running_q   <= 1'b0;
                    step_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.running   = running_q;
    assign bus.step_busy = step_busy_q;

`ifdef CLK_CTRL_CYCLE_CNT_EN
    logic [31:0] cycles_q;

    // Clear wins over a same-cycle increment
    always_ff @(posedge clkin) begin
        if (!reset) begin
            cycles_q <= '0;
        end else if (bus.cnt_clr) begin
            cycles_q <= '0;
        end else if (cpu_ce_q) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign bus.cpu_cycles = cycles_q;
`endif
endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller (IN_CLK_FRQ=100, DEFAULT_FRQ=10 -> divide by 10).
// Inputs change and outputs are sampled on the falling edge.
module tb_cpu_clock_controller;
    localparam int unsigned CNT_W = 32;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    cpu_clock_controller_if #(.CNT_W(CNT_W)) bus ();

    cpu_clock_controller #(
        .IN_CLK_FRQ  (100),
        .DEFAULT_FRQ (10),
        .CNT_W       (CNT_W)
    ) dut (
        .clkin (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus.run_req    = 1'b0;
        bus.halt_req   = 1'b0;
        bus.step_req   = 1'b0;
        bus.cpu_halted = 1'b0;
        bus.cfg_wr     = 1'b0;
        bus.cfg_div    = '0;
`ifdef CLK_CTRL_CYCLE_CNT_EN
        bus.cnt_clr    = 1'b0;
`endif
        repeat (3) cyc();
        check_eq("rst_ce",        32'(bus.cpu_ce),    0);
        check_eq("rst_running",   32'(bus.running),   0);
        check_eq("rst_step_busy", 32'(bus.step_busy), 0);
        reset = 1'b1;
        cyc();

        // Free run at the default ratio: one pulse every 10 cycles
        bus.run_req = 1'b1;
        cyc();
        bus.run_req = 1'b0;
        check_eq("run_entry", 32'(bus.running), 1);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            check_eq("run_ce", 32'(bus.cpu_ce), 32'((i % 10) == 0));
        end
        bus.halt_req = 1'b1;
        cyc();
        bus.halt_req = 1'b0;
        check_eq("halt_running", 32'(bus.running), 0);
        check_eq("halt_ce",      32'(bus.cpu_ce),  0);

        // Single step with a second step request that must be ignored
        bus.step_req = 1'b1;
        cyc();
        bus.step_req = 1'b0;
        check_eq("step_entry", 32'(bus.step_busy), 1);
        check_eq("step_norun", 32'(bus.running),   0);
        for (int i = 1; i <= 25; i++) begin
            cyc();
            check_eq("step_ce",   32'(bus.cpu_ce),    32'(i == 10));
            check_eq("step_busy", 32'(bus.step_busy), 32'(i < 10));
            check_eq("step_run",  32'(bus.running),   0);
            if (i == 3) bus.step_req = 1'b1;
            if (i == 4) bus.step_req = 1'b0;
        end

        // Reload divider on the cycle that would have ticked
        bus.run_req = 1'b1;
        cyc();
        bus.run_req = 1'b0;
        check_eq("run2_entry", 32'(bus.running), 1);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            check_eq("run2_ce", 32'(bus.cpu_ce), 0);
        end
        bus.cfg_wr  = 1'b1;
        bus.cfg_div = 32'd3;
        cyc();
        bus.cfg_wr = 1'b0;
        check_eq("cfg_no_tick", 32'(bus.cpu_ce),  0);
        check_eq("cfg_keep_run", 32'(bus.running), 1);
        for (int j = 1; j <= 12; j++) begin
            cyc();
            check_eq("div4_ce", 32'(bus.cpu_ce), 32'((j % 4) == 0));
        end
        bus.cfg_wr  = 1'b1;
        bus.cfg_div = 32'd0;
        cyc();
        bus.cfg_wr = 1'b0;
        check_eq("div0_load", 32'(bus.cpu_ce), 0);
        for (int j = 1; j <= 5; j++) begin
            cyc();
            check_eq("div0_ce", 32'(bus.cpu_ce), 1);
        end

        // CPU HLT on a tick cycle, then a run request while still halted
        bus.cpu_halted = 1'b1;
        cyc();
        check_eq("hlt_ce",      32'(bus.cpu_ce),  0);
        check_eq("hlt_running", 32'(bus.running), 0);
        bus.run_req = 1'b1;
        cyc();
        bus.run_req = 1'b0;
        check_eq("hlt_run_ignored", 32'(bus.running), 0);
        cyc();
        check_eq("hlt_run_ignored2", 32'(bus.running), 0);
        bus.cpu_halted = 1'b0;
        bus.cfg_wr     = 1'b1;
        bus.cfg_div    = 32'd9;
        cyc();
        bus.cfg_wr = 1'b0;

        // Halt edge beats run edge in the same cycle
        bus.halt_req = 1'b1;
        bus.run_req  = 1'b1;
        cyc();
        bus.halt_req = 1'b0;
        bus.run_req  = 1'b0;
        check_eq("halt_vs_run", 32'(bus.running), 0);
        cyc();
        check_eq("halt_vs_run2", 32'(bus.running), 0);

        // run_req held high through reset produces no edge
        bus.run_req = 1'b1;
        reset       = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        repeat (3) cyc();
        check_eq("held_run_no_edge", 32'(bus.running), 0);
        bus.run_req = 1'b0;
        cyc();
`ifdef CLK_CTRL_CYCLE_CNT_EN
        check_eq("cyc_rst", bus.cpu_cycles, 0);
`endif

        bus.run_req = 1'b1;
        cyc();
        bus.run_req = 1'b0;
        check_eq("run3_entry", 32'(bus.running), 1);
`ifdef CLK_CTRL_CYCLE_CNT_EN
        repeat (50) cyc();
        check_eq("cyc_p5_ce", 32'(bus.cpu_ce), 1);
        check_eq("cyc_4",     bus.cpu_cycles,  4);
        cyc();
        check_eq("cyc_5",     bus.cpu_cycles,  5);
        repeat (9) cyc();
        check_eq("cyc_p6_ce", 32'(bus.cpu_ce), 1);
        bus.cnt_clr = 1'b1;
        cyc();
        bus.cnt_clr = 1'b0;
        check_eq("cyc_clr",   bus.cpu_cycles,  0);
`else
        repeat (5) cyc();
`endif

        // Reset mid-RUN
        reset = 1'b0;
        cyc();
        check_eq("rst_run_ce",      32'(bus.cpu_ce),    0);
        check_eq("rst_run_running", 32'(bus.running),   0);
        check_eq("rst_run_busy",    32'(bus.step_busy), 0);
        reset = 1'b1;
        cyc();
        check_eq("rst_run_stay", 32'(bus.running), 0);

        // Reset mid-STEP drops the pending pulse
        bus.step_req = 1'b1;
        cyc();
        bus.step_req = 1'b0;
        check_eq("step2_entry", 32'(bus.step_busy), 1);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check_eq("rst_step_busy2", 32'(bus.step_busy), 0);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            check_eq("rst_step_ce", 32'(bus.cpu_ce), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
